// File: rtl/keypad_entry_if.sv
// Keypad entry signal bundle: raw switch/button inputs and the registered strobe/digit outputs.
interface keypad_entry_if;
    logic [3:0] sw;
    logic       btn_enter;
    logic       btn_lock;
    logic [3:0] x;
    logic       enter;
    logic       lock;
    logic [7:0] seven_segment_data;
    logic [3:0] seven_segment_enable;

    modport master (
        output sw, btn_enter, btn_lock,
        input  x, enter, lock, seven_segment_data, seven_segment_enable
    );

    modport slave (
        input  sw, btn_enter, btn_lock,
        output x, enter, lock, seven_segment_data, seven_segment_enable
    );
endinterface

// File: rtl/keypad_entry.sv
// Keypad entry: synchronizes raw inputs, debounces enter/lock, and latches the digit on enter.
// Define KEYPAD_ECHO_EN to drive the entered digit onto the seven-segment display.
module keypad_entry #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input logic           clk,
    input logic           reset_n,
    keypad_entry_if.slave bus
);
    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CntW-1:0] CntMax  = '1;

    typedef enum logic [1:0] {Released, PressWait, Pressed, ReleaseWait} deb_state_e;

    // Index 0 is the enter button, index 1 the lock button.
    logic [3:0] sw_meta, sw_sync;
    logic [1:0] btn_meta, btn_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sw_meta  <= '0;
            sw_sync  <= '0;
            btn_meta <= '0;
            btn_sync <= '0;
        end else begin
            sw_meta  <= bus.sw;
            sw_sync  <= sw_meta;
            btn_meta <= {bus.btn_lock, bus.btn_enter};
            btn_sync <= btn_meta;
        end
    end

    deb_state_e      state_q [2];
    deb_state_e      state_d [2];
    logic [CntW-1:0] cnt_q   [2];
    logic [CntW-1:0] cnt_d   [2];
    logic [1:0]      fire;

    always_comb begin
        fire = '0;
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            unique case (state_q[i])
                Released: begin
                    if (btn_sync[i]) begin
                        state_d[i] = PressWait;
                        cnt_d[i]   = '0;
                    end
                end
                PressWait: begin
                    if (!btn_sync[i]) begin
                        state_d[i] = Released;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CntLast) begin
                        state_d[i] = Pressed;
                        cnt_d[i]   = '0;
                        fire[i]    = 1'b1;
                    end else if (cnt_q[i] != CntMax) begin
                        cnt_d[i] = cnt_q[i] + CntW'(1);
                    end
                end
                Pressed: begin
                    if (!btn_sync[i]) begin
                        state_d[i] = ReleaseWait;
                        cnt_d[i]   = '0;
                    end
                end
                ReleaseWait: begin
                    if (btn_sync[i]) begin
                        state_d[i] = Pressed;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CntLast) begin
                        state_d[i] = Released;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] != CntMax) begin
                        cnt_d[i] = cnt_q[i] + CntW'(1);
                    end
                end
                default: begin
                    state_d[i] = Released;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= Released;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Lock wins a same-cycle collision; the digit is only taken on a real enter.
    logic       accept_enter;
    logic [3:0] x_q;
    logic       enter_q, lock_q;

    assign accept_enter = fire[0] & ~fire[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q     <= '0;
            enter_q <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            enter_q <= accept_enter;
            lock_q  <= fire[1];
            if (accept_enter) begin
                x_q <= sw_sync;
            end
        end
    end

    assign bus.x     = x_q;
    assign bus.enter = enter_q;
    assign bus.lock  = lock_q;

`ifdef KEYPAD_ECHO_EN
    function automatic logic [7:0] hex_glyph(input logic [3:0] d);
        unique case (d)
            4'h0: hex_glyph = 8'hC0;
            4'h1: hex_glyph = 8'hF9;
            4'h2: hex_glyph = 8'hA4;
            4'h3: hex_glyph = 8'hB0;
            4'h4: hex_glyph = 8'h99;
            4'h5: hex_glyph = 8'h92;
            4'h6: hex_glyph = 8'h82;
            4'h7: hex_glyph = 8'hF8;
            4'h8: hex_glyph = 8'h80;
            4'h9: hex_glyph = 8'h90;
            4'hA: hex_glyph = 8'h88;
            4'hB: hex_glyph = 8'h83;
            4'hC: hex_glyph = 8'hC6;
            4'hD: hex_glyph = 8'hA1;
            4'hE: hex_glyph = 8'h86;
            default: hex_glyph = 8'h8E;
        endcase
    endfunction

    // x only changes on an accepted enter, so decoding it tracks each entry.
    assign bus.seven_segment_data   = hex_glyph(x_q);
    assign bus.seven_segment_enable = 4'b1110;
`else
    assign bus.seven_segment_data   = 8'hFF;
    assign bus.seven_segment_enable = 4'b1111;
`endif
endmodule
